// File: rtl/k_sqrt_pkg.sv
// k_sqrt_pkg
// Shared definitions for the approximate FP16 square-root block:
//   - FP16 field positions
//   - special-value constants and the exponent bias
//   - the two 4-entry mantissa tables (even / odd unbiased exponent)
//   - operand classification type and helper
package k_sqrt_pkg;

    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MANT_MSB = 9;
    localparam int MANT_LSB = 0;

    localparam logic [15:0] QNAN = 16'h7E00;
    localparam logic [15:0] PINF = 16'h7C00;
    localparam logic [5:0]  BIAS = 6'd15;

    // Segment k holds round((sqrt(1 + k/4 + 1/8) - 1) * 1024); index 0 is the LSB entry.
    localparam logic [3:0][9:0] EVEN_MANT = {10'd378, 10'd281, 10'd177, 10'd62};
    // Same midpoints scaled by 2 (odd unbiased exponent leaves a factor of 2 under the root).
    localparam logic [3:0][9:0] ODD_MANT  = {10'd959, 10'd822, 10'd674, 10'd512};

    typedef enum logic [2:0] {
        CLS_NORMAL,
        CLS_ZERO,
        CLS_SUBNORMAL,
        CLS_NAN,
        CLS_NEGATIVE,
        CLS_PINF
    } class_e;

    // Priority order matters: signed zero wins over "negative", NaN wins over sign.
    function automatic class_e classify(input logic [15:0] x);
        logic [4:0] e;
        logic [9:0] m;
        class_e     c;
        e = x[EXP_MSB:EXP_LSB];
        m = x[MANT_MSB:MANT_LSB];
        if (e == 5'd0 && m == 10'd0)       c = CLS_ZERO;
        else if (e == 5'd0)                c = CLS_SUBNORMAL;
        else if (e == 5'd31 && m != 10'd0) c = CLS_NAN;
        else if (x[SIGN_BIT])              c = CLS_NEGATIVE;
        else if (e == 5'd31)               c = CLS_PINF;
        else                               c = CLS_NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/k_4_sqrt_lut.sv
// k_4_sqrt_lut
// Piecewise-constant mantissa table for the approximate square root.
//   parity : 1 when the unbiased exponent is odd (selects the ODD table)
//   seg    : top two mantissa bits of the operand
//   mant   : 10-bit result mantissa
module k_4_sqrt_lut
    import k_sqrt_pkg::*;
(
    input  logic       parity,
    input  logic [1:0] seg,
    output logic [9:0] mant
);

    always_comb begin
        mant = parity ? ODD_MANT[seg] : EVEN_MANT[seg];
    end

endmodule

// File: rtl/k_4_sqrt.sv
// k_4_sqrt
// Two-stage approximate FP16 square root with valid/ready handshakes.
// S1 registers operand classification and decoded fields, S2 registers the
// assembled result. Full throughput of one result per cycle, two in flight.
//   clk, rst_n            : clock, asynchronous active-low reset
//   in_valid/in_ready     : operand handshake, in_data = FP16 operand
//   out_valid/out_ready   : result handshake, out_data = FP16 approx sqrt
//   out_special           : result came from the zero/subnormal/NaN/neg/inf path
//   result_cnt            : completed output handshakes, wraps modulo 2^CNT_W
module k_4_sqrt
    import k_sqrt_pkg::*;
#(
    parameter int CNT_W = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic             out_special,
    output logic [CNT_W-1:0] result_cnt
);

    logic       s1_valid;
    class_e     s1_class;
    logic       s1_sign;
    logic       s1_parity;
    logic [1:0] s1_seg;
    logic [4:0] s1_exp;

    logic        s2_load;
    logic        in_fire;
    logic [4:0]  in_exp;
    logic [4:0]  exp_half;
    logic [9:0]  lut_mant;
    logic [15:0] s2_result;
    logic        s2_special;

    // S2 can take a new entry when it is empty or its result leaves this
    // cycle; S1 shifts into S2 under the same condition, so no bubbles.
    assign s2_load  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_load;
    assign in_fire  = in_valid && in_ready;

    // Halving the biased exponent: (E + 15) >> 1 needs a 6-bit sum.
    assign in_exp   = in_data[EXP_MSB:EXP_LSB];
    assign exp_half = 5'(({1'b0, in_exp} + BIAS) >> 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_class  <= CLS_NORMAL;
            s1_sign   <= 1'b0;
            s1_parity <= 1'b0;
            s1_seg    <= 2'd0;
            s1_exp    <= 5'd0;
        end else if (in_fire) begin
            s1_valid  <= 1'b1;
            s1_class  <= classify(in_data);
            s1_sign   <= in_data[SIGN_BIT];
            // Even biased exponent means odd unbiased exponent.
            s1_parity <= ~in_exp[0];
            s1_seg    <= in_data[MANT_MSB -: 2];
            s1_exp    <= exp_half;
        end else if (s2_load) begin
            s1_valid  <= 1'b0;
        end
    end

    k_4_sqrt_lut u_lut (
        .parity (s1_parity),
        .seg    (s1_seg),
        .mant   (lut_mant)
    );

    always_comb begin
        s2_result  = 16'h0000;
        s2_special = 1'b1;
        case (s1_class)
            CLS_NORMAL: begin
                s2_result  = {1'b0, s1_exp, lut_mant};
                s2_special = 1'b0;
            end
            CLS_ZERO:      s2_result = {s1_sign, 15'd0};
            CLS_SUBNORMAL: s2_result = 16'h0000;
            CLS_NAN:       s2_result = QNAN;
            CLS_NEGATIVE:  s2_result = QNAN;
            CLS_PINF:      s2_result = PINF;
            default:       s2_result = QNAN;
        endcase
    end

    // Data only updates when a real entry moves in, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_data    <= 16'h0000;
            out_special <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data    <= s2_result;
                out_special <= s2_special;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_cnt <= '0;
        end else if (out_valid && out_ready) begin
            result_cnt <= result_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_k_4_sqrt.sv
// tb_k_4_sqrt
// Self-checking bench for k_4_sqrt: directed literal results, backpressure,
// throughput, mid-flight reset and a randomized run against a floating-point
// reference model with an in-order scoreboard.
module tb_k_4_sqrt;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [15:0]      in_data;
    logic             out_valid;
    logic             out_ready;
    logic [15:0]      out_data;
    logic             out_special;
    logic [CNT_W-1:0] result_cnt;

    int compared;
    int mismatched;

    logic [16:0] expQ[$];
    int          outCycles[$];
    int          cycle;
    int          modelCnt;
    int          stalls;
    logic        randReady;

    k_4_sqrt #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_special (out_special),
        .result_cnt  (result_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: real-valued sqrt of the segment midpoint, exponent halved arithmetically.
    function automatic logic [16:0] refSqrt(input logic [15:0] x);
        logic [4:0] e;
        logic [9:0] m;
        int         u;
        int         half;
        int         mant;
        bit         odd;
        real        frac;
        e = x[14:10];
        m = x[9:0];
        if (e == 0 && m == 0) return {1'b1, x};
        if (e == 0)           return {1'b1, 16'h0000};
        if (e == 31 && m != 0) return {1'b1, 16'h7E00};
        if (x[15])            return {1'b1, 16'h7E00};
        if (e == 31)          return {1'b1, 16'h7C00};
        u    = int'(e) - 15;
        odd  = (u % 2) != 0;
        half = odd ? (u - 1) / 2 : u / 2;
        frac = 1.0 + 0.25 * real'(int'(m[9:8])) + 0.125;
        if (odd) frac = frac * 2.0;
        mant = $rtoi(($sqrt(frac) - 1.0) * 1024.0 + 0.5);
        return {1'b0, 1'b0, 5'(half + 15), 10'(mant)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives one operand and returns #1 after the edge where it was accepted.
    task automatic applyStimulus(input logic [15:0] d);
        bit accepted;
        int waited;
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        accepted = 1'b0;
        while (!accepted) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            if (!accepted) begin
                waited++;
                if (waited > 60) begin
                    checkOutput("accept_timeout", 32'(waited), 32'd0);
                    accepted = 1'b1;
                end
            end
        end
        if (waited != 0) stalls++;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || out_valid) && n < 60) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_timeout", 32'(expQ.size()), 32'd0);
    endtask

    // Scoreboard / compare process: evaluated mid-cycle, describing the next edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            expQ.delete();
            modelCnt = 0;
            checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
            checkOutput("reset_result_cnt", 32'(result_cnt), 32'd0);
        end else begin
            cycle++;
            checkOutput("result_cnt", 32'(result_cnt), 32'(modelCnt % (1 << CNT_W)));
            checkOutput("in_ready", 32'(in_ready), 32'((expQ.size() < 2) || out_ready));
            if (out_valid) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious_out_valid", 32'(out_valid), 32'd0);
                end else begin
                    checkOutput("scoreboard", {15'd0, out_special, out_data}, {15'd0, expQ[0]});
                    if (out_ready) begin
                        void'(expQ.pop_front());
                        modelCnt++;
                        outCycles.push_back(cycle);
                    end
                end
            end
            if (in_valid && in_ready) expQ.push_back(refSqrt(in_data));
        end
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic doReset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] dirIn  [14];
    logic [15:0] dirOut [14];
    logic        dirSp  [14];
    logic [15:0] bpData [4];

    initial begin
        compared   = 0;
        mismatched = 0;
        cycle      = 0;
        modelCnt   = 0;
        stalls     = 0;
        randReady  = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 16'h0000;
        out_ready  = 1'b0;

        dirIn[0]  = 16'h3C00; dirOut[0]  = 16'h3C3E; dirSp[0]  = 1'b0;
        dirIn[1]  = 16'h4400; dirOut[1]  = 16'h403E; dirSp[1]  = 1'b0;
        dirIn[2]  = 16'h4000; dirOut[2]  = 16'h3E00; dirSp[2]  = 1'b0;
        dirIn[3]  = 16'h4300; dirOut[3]  = 16'h3FBF; dirSp[3]  = 1'b0;
        dirIn[4]  = 16'h7BFF; dirOut[4]  = 16'h5BBF; dirSp[4]  = 1'b0;
        dirIn[5]  = 16'h0400; dirOut[5]  = 16'h203E; dirSp[5]  = 1'b0;
        dirIn[6]  = 16'hC000; dirOut[6]  = 16'h7E00; dirSp[6]  = 1'b1;
        dirIn[7]  = 16'h8000; dirOut[7]  = 16'h8000; dirSp[7]  = 1'b1;
        dirIn[8]  = 16'h0001; dirOut[8]  = 16'h0000; dirSp[8]  = 1'b1;
        dirIn[9]  = 16'h7C00; dirOut[9]  = 16'h7C00; dirSp[9]  = 1'b1;
        dirIn[10] = 16'hFC00; dirOut[10] = 16'h7E00; dirSp[10] = 1'b1;
        dirIn[11] = 16'h7E01; dirOut[11] = 16'h7E00; dirSp[11] = 1'b1;
        dirIn[12] = 16'h0000; dirOut[12] = 16'h0000; dirSp[12] = 1'b1;
        dirIn[13] = 16'h7D00; dirOut[13] = 16'h7E00; dirSp[13] = 1'b1;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_out_data", 32'(out_data), 32'h0000);
        checkOutput("rst_out_special", 32'(out_special), 32'd0);
        checkOutput("rst_result_cnt", 32'(result_cnt), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed literal results, two cycles after the accepting edge.
        out_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(dirIn[i]);
            checkOutput("latency_early", 32'(out_valid), 32'd0);
            @(posedge clk);
            #1;
            checkOutput($sformatf("dir_valid_%h", dirIn[i]), 32'(out_valid), 32'd1);
            checkOutput($sformatf("dir_data_%h", dirIn[i]), 32'(out_data), 32'(dirOut[i]));
            checkOutput($sformatf("dir_special_%h", dirIn[i]), 32'(out_special), 32'(dirSp[i]));
        end
        waitDrain();

        // Backpressure: four operands, output stalled for five cycles.
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) bpData[i] = {1'b0, 5'($urandom_range(1, 30)), 10'($urandom)};
        applyStimulus(bpData[0]);
        applyStimulus(bpData[1]);
        fork
            begin
                applyStimulus(bpData[2]);
                applyStimulus(bpData[3]);
            end
            begin
                repeat (5) begin
                    checkOutput("bp_in_ready_low", 32'(in_ready), 32'd0);
                    checkOutput("bp_hold_data", 32'(out_data), 32'(refSqrt(bpData[0])));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_result_cnt", 32'(result_cnt), 32'd4);

        // Throughput: eight back-to-back operands.
        outCycles.delete();
        stalls = 0;
        for (int i = 0; i < 8; i++) applyStimulus({1'b0, 5'($urandom_range(1, 30)), 10'($urandom)});
        waitDrain();
        checkOutput("tp_stalls", 32'(stalls), 32'd0);
        checkOutput("tp_count", 32'(outCycles.size()), 32'd8);
        if (outCycles.size() == 8)
            checkOutput("tp_consecutive", 32'(outCycles[7] - outCycles[0]), 32'd7);

        // Mid-flight reset discards in-flight operands.
        out_ready = 1'b0;
        applyStimulus(16'h4400);
        applyStimulus(16'h4000);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_result_cnt", 32'(result_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_stale", 32'(out_valid), 32'd0);
        end
        applyStimulus(16'h3C00);
        @(posedge clk);
        #1;
        checkOutput("midrst_new_data", 32'(out_data), 32'h3C3E);
        waitDrain();

        // Randomized run with random output stalls; counter wraps several times.
        randReady = 1'b1;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(16'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
        end
        randReady = 1'b0;
        #2;
        out_ready = 1'b1;
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
